// File: rtl/pulse_check_pkg.sv
// Shared FSM state type and event shape check for pulse_sequence_checker.
package pulse_check_pkg;

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} pc_state_e;

  // Upper bounds for the channel vector handled by shape_ok.
  localparam int unsigned MAX_CH    = 256;
  localparam int unsigned MAX_IDX_W = 8;

  // The vector arrives zero-extended to MAX_CH, so nch marks the live channels.
  function automatic logic shape_ok(input logic [MAX_CH-1:0]    vec,
                                    input logic                 rolling,
                                    input logic [MAX_IDX_W-1:0] idx,
                                    input int unsigned          nch);
    logic [MAX_CH-1:0] allones;
    logic [MAX_CH-1:0] onehot;
    for (int unsigned i = 0; i < MAX_CH; i++) allones[i] = (i < nch);
    onehot      = '0;
    onehot[idx] = 1'b1;
    return rolling ? (vec == onehot) : (vec == allones);
  endfunction

endpackage

// File: rtl/pulse_onehot_decode.sv
// Combinational classifier for a pulse vector: one-hot, all-ones, lowest set index.
module pulse_onehot_decode #(
  parameter int unsigned NUMCHANNELS = 64
) (
  input  logic [NUMCHANNELS-1:0]         periodic_pulse,
  output logic                           is_onehot,
  output logic                           is_allones,
  output logic [$clog2(NUMCHANNELS)-1:0] index
);

  localparam int unsigned IDXW = $clog2(NUMCHANNELS);

  always_comb begin
    is_allones = &periodic_pulse;
    is_onehot  = (periodic_pulse != '0) &&
                 ((periodic_pulse & (periodic_pulse - NUMCHANNELS'(1))) == '0);
    index      = '0;
    for (int unsigned i = NUMCHANNELS; i > 0; i--) begin
      if (periodic_pulse[i-1]) index = IDXW'(i - 1);
    end
  end

endmodule

// File: rtl/pulse_sequence_checker.sv
// Checks a periodic pulse stream for period, presence and channel order.
// Define PULSE_CHECK_STATS_EN to implement the event_count counter.
module pulse_sequence_checker
  import pulse_check_pkg::*;
#(
  parameter int unsigned PERIODIC_PULSER_W = 32,
  parameter int unsigned NUMCHANNELS       = 64,
  parameter int unsigned EVENT_COUNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUMCHANNELS-1:0]         periodic_pulse,
  input  logic [PERIODIC_PULSER_W-1:0]   pulse_cycles,
  input  logic                           enable,
  input  logic                           expect_rolling,
  input  logic                           clear_errors,
  output logic                           locked,
  output logic                           period_error,
  output logic                           missing_error,
  output logic                           order_error,
  output logic [$clog2(NUMCHANNELS)-1:0] err_index,
  output logic [EVENT_COUNT_W-1:0]       event_count
);

  localparam int unsigned IDXW = $clog2(NUMCHANNELS);

  pc_state_e                    state_q, state_d;
  logic [PERIODIC_PULSER_W-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0]              exp_idx_q, exp_idx_d;
  logic                         per_q, per_d, miss_q, miss_d, ord_q, ord_d;
  logic [IDXW-1:0]              err_idx_q, err_idx_d;
  logic                         per_e, miss_e, ord_e, good_evt;

  logic            dec_onehot, dec_allones;
  logic [IDXW-1:0] dec_index;
  logic            evt;

  pulse_onehot_decode #(.NUMCHANNELS(NUMCHANNELS)) u_decode (
    .periodic_pulse (periodic_pulse),
    .is_onehot      (dec_onehot),
    .is_allones     (dec_allones),
    .index          (dec_index)
  );

  assign evt = (periodic_pulse != '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exp_idx_d = exp_idx_q;
    per_e     = 1'b0;
    miss_e    = 1'b0;
    ord_e     = 1'b0;
    good_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pulse_cycles != '0) state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (evt) begin
          if (dec_allones || dec_onehot) begin
            exp_idx_d = dec_index + IDXW'(1);
            cnt_d     = '0;
            state_d   = TRACK;
          end else begin
            ord_e = 1'b1;
          end
        end
      end
      TRACK: begin
        // '>' rather than '== pulse_cycles+1' so a period shortened mid-track still times out
        if (cnt_q > pulse_cycles) begin
          miss_e = 1'b1;
        end else if (evt) begin
          if (cnt_q < pulse_cycles) begin
            per_e = 1'b1;
          end else if (shape_ok(MAX_CH'(periodic_pulse), expect_rolling,
                                MAX_IDX_W'(exp_idx_q), NUMCHANNELS)) begin
            good_evt = 1'b1;
            cnt_d    = '0;
            if (expect_rolling) exp_idx_d = exp_idx_q + IDXW'(1);
          end else begin
            ord_e = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + PERIODIC_PULSER_W'(1);
        end
        if (per_e || miss_e || ord_e) state_d = ACQUIRE;
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d  = IDLE;
      per_e    = 1'b0;
      miss_e   = 1'b0;
      ord_e    = 1'b0;
      good_evt = 1'b0;
    end

    per_d     = (per_q  & ~clear_errors) | per_e;
    miss_d    = (miss_q & ~clear_errors) | miss_e;
    ord_d     = (ord_q  & ~clear_errors) | ord_e;
    err_idx_d = err_idx_q;
    if (!(per_q || miss_q || ord_q) && (per_e || miss_e || ord_e)) err_idx_d = exp_idx_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      exp_idx_q <= '0;
      per_q     <= 1'b0;
      miss_q    <= 1'b0;
      ord_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      exp_idx_q <= exp_idx_d;
      per_q     <= per_d;
      miss_q    <= miss_d;
      ord_q     <= ord_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign locked        = (state_q == TRACK);
  assign period_error  = per_q;
  assign missing_error = miss_q;
  assign order_error   = ord_q;
  assign err_index     = err_idx_q;

`ifdef PULSE_CHECK_STATS_EN
  logic [EVENT_COUNT_W-1:0] evcnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evcnt_q <= '0;
    end else if (good_evt && (evcnt_q != '1)) begin
      evcnt_q <= evcnt_q + EVENT_COUNT_W'(1);
    end
  end

  assign event_count = evcnt_q;
`else
  assign event_count = '0;
`endif

endmodule

// File: tb/tb_pulse_sequence_checker.sv
// Scoreboard bench for pulse_sequence_checker with 8 channels.
module tb_pulse_sequence_checker;

  localparam int unsigned NCH = 8;
`ifdef PULSE_CHECK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic        locked;
    logic        per;
    logic        miss;
    logic        ord;
    logic [2:0]  eidx;
    logic [15:0] cnt;
  } obs_t;

  typedef struct packed {
    logic           clr;
    logic [NCH-1:0] pulse;
  } stim_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           enable = 1'b0;
  logic           expect_rolling = 1'b0;
  logic           clear_errors = 1'b0;
  logic [NCH-1:0] periodic_pulse = '0;
  logic [31:0]    pulse_cycles = 32'd3;
  logic           locked, period_error, missing_error, order_error;
  logic [2:0]     err_index;
  logic [15:0]    event_count;

  int    checks = 0;
  int    failures = 0;
  stim_t stim_q[$];
  obs_t  exp_q[$];

  always #5 clk = ~clk;

  pulse_sequence_checker #(
    .PERIODIC_PULSER_W (32),
    .NUMCHANNELS       (NCH),
    .EVENT_COUNT_W     (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .periodic_pulse (periodic_pulse),
    .pulse_cycles   (pulse_cycles),
    .enable         (enable),
    .expect_rolling (expect_rolling),
    .clear_errors   (clear_errors),
    .locked         (locked),
    .period_error   (period_error),
    .missing_error  (missing_error),
    .order_error    (order_error),
    .err_index      (err_index),
    .event_count    (event_count)
  );

  function automatic obs_t mk(input logic l, input logic p, input logic m, input logic o,
                              input int unsigned idx, input int unsigned c);
    obs_t r;
    r.locked = l;
    r.per    = p;
    r.miss   = m;
    r.ord    = o;
    r.eidx   = 3'(idx);
    r.cnt    = STATS ? 16'(c) : 16'd0;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r.locked = locked;
    r.per    = period_error;
    r.miss   = missing_error;
    r.ord    = order_error;
    r.eidx   = err_index;
    r.cnt    = event_count;
    return r;
  endfunction

  function automatic logic [NCH-1:0] ch(input int unsigned i);
    logic [NCH-1:0] one;
    one = NCH'(1);
    return one << i;
  endfunction

  task automatic push(input logic [NCH-1:0] p, input logic clr, input obs_t e);
    stim_t s;
    s.pulse = p;
    s.clr   = clr;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    enable = 1'b0;
    clear_errors = 1'b0;
    periodic_pulse = '0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    stim_t s;
    obs_t e, got;
    int n;
    #1 reset = 1'b1;
    #1;
    got = sample(); checks++;
    if (got !== mk(0,0,0,0,0,0)) begin
      failures++; $display("FAIL reset_async got=%h exp=%h", got, mk(0,0,0,0,0,0));
    end
    @(posedge clk); #1;
    reset = 1'b0;
    pulse_cycles = 32'd3; expect_rolling = 1'b0; enable = 1'b1;
    push('0, 1'b0, mk(0,0,0,0,0,0));
    for (int k = 1; k <= 8; k++) begin
      push(8'hFF, 1'b0, mk(1,0,0,0,0,k-1));
      if (k < 8) for (int j = 0; j < 3; j++) push('0, 1'b0, mk(1,0,0,0,0,k-1));
    end
    n = 0;
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      periodic_pulse = s.pulse; clear_errors = s.clr;
      @(posedge clk); #1;
      periodic_pulse = '0; clear_errors = 1'b0;
      e = exp_q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL reset_prep[%0d] got=%h exp=%h", n, got, e);
      end
      n++;
    end
    #3 reset = 1'b1;
    #1;
    got = sample(); checks++;
    if (got !== mk(0,0,0,0,0,0)) begin
      failures++; $display("FAIL reset_mid_track got=%h exp=%h", got, mk(0,0,0,0,0,0));
    end
    #1 reset = 1'b0;
    pulse_cycles = 32'd0;
    push('0,      1'b0, mk(0,0,0,0,0,0));
    push(8'h03,   1'b0, mk(0,0,0,0,0,0));
    push(ch(4),   1'b0, mk(0,0,0,0,0,0));
    push(8'hFF,   1'b0, mk(0,0,0,0,0,0));
    push(8'h05,   1'b0, mk(0,0,0,0,0,0));
    n = 0;
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      periodic_pulse = s.pulse; clear_errors = s.clr;
      @(posedge clk); #1;
      periodic_pulse = '0; clear_errors = 1'b0;
      e = exp_q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL zero_period_idle[%0d] got=%h exp=%h", n, got, e);
      end
      n++;
    end
    pulse_cycles = 32'd3;
  endtask

  task automatic test_all_mode();
    stim_t s;
    obs_t e, got;
    int n;
    apply_reset();
    pulse_cycles = 32'd3; expect_rolling = 1'b0; enable = 1'b1;
    push('0, 1'b0, mk(0,0,0,0,0,0));
    for (int k = 1; k <= 11; k++) begin
      push(8'hFF, 1'b0, mk(1,0,0,0,0,k-1));
      if (k < 11) for (int j = 0; j < 3; j++) push('0, 1'b0, mk(1,0,0,0,0,k-1));
    end
    n = 0;
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      periodic_pulse = s.pulse; clear_errors = s.clr;
      @(posedge clk); #1;
      periodic_pulse = '0; clear_errors = 1'b0;
      e = exp_q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL all_mode[%0d] got=%h exp=%h", n, got, e);
      end
      n++;
    end
  endtask

  task automatic test_rolling();
    stim_t s;
    obs_t e, got;
    int n;
    int unsigned chans[5] = '{5, 6, 7, 0, 1};
    apply_reset();
    pulse_cycles = 32'd3; expect_rolling = 1'b1; enable = 1'b1;
    push('0, 1'b0, mk(0,0,0,0,0,0));
    for (int k = 0; k < 5; k++) begin
      push(ch(chans[k]), 1'b0, mk(1,0,0,0,0,k));
      if (k < 4) for (int j = 0; j < 3; j++) push('0, 1'b0, mk(1,0,0,0,0,k));
    end
    n = 0;
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      periodic_pulse = s.pulse; clear_errors = s.clr;
      @(posedge clk); #1;
      periodic_pulse = '0; clear_errors = 1'b0;
      e = exp_q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL rolling_wrap[%0d] got=%h exp=%h", n, got, e);
      end
      n++;
    end
  endtask

  task automatic test_period_error();
    stim_t s;
    obs_t e, got;
    int n;
    apply_reset();
    pulse_cycles = 32'd3; expect_rolling = 1'b1; enable = 1'b1;
    push('0,    1'b0, mk(0,0,0,0,0,0));
    push(ch(0), 1'b0, mk(1,0,0,0,0,0));
    for (int j = 0; j < 3; j++) push('0, 1'b0, mk(1,0,0,0,0,0));
    push(ch(1), 1'b0, mk(1,0,0,0,0,1));
    push('0,    1'b0, mk(1,0,0,0,0,1));
    push(ch(2), 1'b0, mk(0,1,0,0,2,1));
    for (int j = 0; j < 3; j++) push('0, 1'b0, mk(0,1,0,0,2,1));
    push(ch(3), 1'b0, mk(1,1,0,0,2,1));
    for (int j = 0; j < 3; j++) push('0, 1'b0, mk(1,1,0,0,2,1));
    push(ch(4), 1'b0, mk(1,1,0,0,2,2));
    n = 0;
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      periodic_pulse = s.pulse; clear_errors = s.clr;
      @(posedge clk); #1;
      periodic_pulse = '0; clear_errors = 1'b0;
      e = exp_q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL period_error[%0d] got=%h exp=%h", n, got, e);
      end
      n++;
    end
  endtask

  task automatic test_missing_error();
    stim_t s;
    obs_t e, got;
    int n;
    apply_reset();
    pulse_cycles = 32'd3; expect_rolling = 1'b1; enable = 1'b1;
    push('0,    1'b0, mk(0,0,0,0,0,0));
    push(ch(0), 1'b0, mk(1,0,0,0,0,0));
    for (int j = 0; j < 3; j++) push('0, 1'b0, mk(1,0,0,0,0,0));
    push(ch(1), 1'b0, mk(1,0,0,0,0,1));
    for (int j = 0; j < 4; j++) push('0, 1'b0, mk(1,0,0,0,0,1));
    push('0,    1'b0, mk(0,0,1,0,2,1));
    push(ch(5), 1'b1, mk(1,0,0,0,2,1));
    for (int j = 0; j < 3; j++) push('0, 1'b0, mk(1,0,0,0,2,1));
    push(ch(6), 1'b0, mk(1,0,0,0,2,2));
    n = 0;
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      periodic_pulse = s.pulse; clear_errors = s.clr;
      @(posedge clk); #1;
      periodic_pulse = '0; clear_errors = 1'b0;
      e = exp_q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL missing_error[%0d] got=%h exp=%h", n, got, e);
      end
      n++;
    end
  endtask

  task automatic test_order_error();
    stim_t s;
    obs_t e, got;
    int n;
    apply_reset();
    pulse_cycles = 32'd3; expect_rolling = 1'b1; enable = 1'b1;
    push('0,    1'b0, mk(0,0,0,0,0,0));
    push(ch(1), 1'b0, mk(1,0,0,0,0,0));
    for (int j = 0; j < 3; j++) push('0, 1'b0, mk(1,0,0,0,0,0));
    push(ch(2), 1'b0, mk(1,0,0,0,0,1));
    for (int j = 0; j < 3; j++) push('0, 1'b0, mk(1,0,0,0,0,1));
    push(ch(4), 1'b0, mk(0,0,0,1,3,1));
    for (int j = 0; j < 2; j++) push('0, 1'b0, mk(0,0,0,1,3,1));
    push(ch(6), 1'b0, mk(1,0,0,1,3,1));
    push('0,    1'b0, mk(1,0,0,1,3,1));
    push(ch(7), 1'b0, mk(0,1,0,1,3,1));
    push(8'h05, 1'b1, mk(0,0,0,1,3,1));
    push('0,    1'b1, mk(0,0,0,0,3,1));
    n = 0;
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      periodic_pulse = s.pulse; clear_errors = s.clr;
      @(posedge clk); #1;
      periodic_pulse = '0; clear_errors = 1'b0;
      e = exp_q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL order_error[%0d] got=%h exp=%h", n, got, e);
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_all_mode();
    test_rolling();
    test_period_error();
    test_missing_error();
    test_order_error();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/pulse_sequence_checker.md
PULSE_SEQUENCE_CHECKER -- requirements
Module: pulse_sequence_checker

Interface
REQ-001 Parameter PERIODIC_PULSER_W, default 32, SHALL set the width of pulse_cycles and the interval counter.
REQ-002 Parameter NUMCHANNELS, default 64, SHALL set the pulse vector width; it SHALL be a power of two.
REQ-003 Parameter EVENT_COUNT_W, default 16, SHALL set the event_count width.
REQ-004 clk  input  1  master clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 periodic_pulse  input  NUMCHANNELS  pulse vector from the pulser, synchronous to clk.
REQ-007 pulse_cycles  input  PERIODIC_PULSER_W  expected period minus one, in clocks.
REQ-008 enable  input  1  high to enable checking.
REQ-009 expect_rolling  input  1  high when exactly one channel is expected per event; low when all channels are expected.
REQ-010 clear_errors  input  1  single-cycle strobe that clears the sticky error flags.
REQ-011 locked  output  1  high while in TRACK.
REQ-012 period_error  output  1  sticky flag: an event arrived early.
REQ-013 missing_error  output  1  sticky flag: an expected event did not arrive.
REQ-014 order_error  output  1  sticky flag: an event had the wrong shape or index.
REQ-015 err_index  output  clog2(NUMCHANNELS)  expected channel index captured at the first error.
REQ-016 event_count  output  EVENT_COUNT_W  count of good events.

Function
REQ-017 Event SHALL mean periodic_pulse != 0 in a cycle.
REQ-018 Good shape SHALL mean all-ones when expect_rolling=0, and one-hot at exp_idx when expect_rolling=1.
REQ-019 FSM states SHALL be IDLE, ACQUIRE and TRACK.
REQ-020 Any state SHALL go to IDLE when enable=0; IDLE SHALL go to ACQUIRE when enable=1 and pulse_cycles>=1.
REQ-021 pulse_cycles=0 SHALL hold the FSM in IDLE.
REQ-022 ACQUIRE SHALL wait for an event; all-ones or any one-hot SHALL set exp_idx to the next index (the first-seen index + 1, mod NUMCHANNELS), clear the interval counter and enter TRACK; any other shape SHALL set order_error and stay in ACQUIRE.
REQ-023 In TRACK, the interval counter SHALL increment each cycle that has no event.
REQ-024 An event with counter==pulse_cycles and good shape SHALL be good: event_count increments, exp_idx increments mod NUMCHANNELS when rolling, and the counter clears.
REQ-025 An event with counter<pulse_cycles SHALL set period_error.
REQ-026 Reaching counter==pulse_cycles+1 with no event SHALL set missing_error.
REQ-027 An on-time event with bad shape SHALL set order_error.
REQ-028 Any TRACK error SHALL return the FSM to ACQUIRE on the next cycle, with locked falling in that cycle.
REQ-029 Error flags SHALL be registered, asserted one cycle after the offending sample, and sticky.
REQ-030 err_index SHALL load only when all three error flags are clear.
REQ-031 clear_errors SHALL clear all flags; if an error occurs in the same cycle, the new error SHALL win.
REQ-032 event_count SHALL saturate at all-ones and SHALL not be cleared by clear_errors.
REQ-033 Changing pulse_cycles during TRACK SHALL take effect on the next comparison; no other action is required.

Reset
REQ-034 reset SHALL force state IDLE and clear the interval counter, exp_idx, locked, all error flags, err_index and event_count.
REQ-035 Reset mid-TRACK SHALL take effect immediately and asynchronously, with no error logged.

Configuration
REQ-036 With PULSE_CHECK_STATS_EN defined, the event_count counter SHALL be implemented.
REQ-037 Without PULSE_CHECK_STATS_EN, event_count SHALL be tied to 0 and no counter register SHALL be inferred; all other behaviour SHALL be unchanged.

Structure
REQ-038 Package pulse_check_pkg SHALL hold the FSM state enum (IDLE, ACQUIRE, TRACK) and the function shape_ok(vector, rolling, idx).
REQ-039 Sub-module pulse_onehot_decode SHALL be combinational, producing is_onehot, is_allones and index from periodic_pulse.

Verification
REQ-040 NUMCHANNELS=8, pulse_cycles=3, all mode, an all-ones event every 4 clocks -> locked one cycle after the first event, event_count=10 after 11 events, and no errors.
REQ-041 Rolling mode, pulse_cycles=3, one-hot channels 5,6,7,0,1 -> locked; the wrap 7->0 is accepted; event_count=4.
REQ-042 Locked with pulse_cycles=3, then an event 2 clocks after the previous one -> period_error=1, err_index=expected index, locked=0, then relock on the following events.
REQ-043 Locked, then an event is withheld -> missing_error=1 exactly 5 clocks after the last event; clear_errors clears the flag while the FSM reacquires.
REQ-044 Rolling mode with expected channel 3 but channel 4 pulsed on time -> order_error=1 and err_index=3; a later error leaves err_index at 3.
REQ-045 reset pulsed mid-TRACK with event_count=7 -> all outputs 0 asynchronously, state IDLE; pulse_cycles=0 with enable=1 -> the FSM stays in IDLE.
